// File: rtl/branch_predict_unit.sv
// branch_predict_unit
//   Branch target buffer with 2-bit saturating predictors. Fetch looks up the
//   BTB combinationally to produce a predicted next PC. Resolve (from EX)
//   computes the real next PC, flags mispredicts with a registered one-cycle
//   redirect, counts them, and trains the BTB. PCs are word addresses.
//
// Ports
//   clk            : rising-edge clock
//   rst            : asynchronous active-high reset
//   f_pc           : fetch PC
//   f_pred_taken   : predicted taken for f_pc (combinational)
//   f_pred_next    : predicted next PC for f_pc (combinational)
//   r_valid        : resolve strobe, one cycle per branch
//   r_pc           : PC of the resolving branch
//   r_offset       : signed word offset of the branch
//   r_taken        : actual branch outcome
//   r_pred_taken   : prediction carried down the pipe
//   r_pred_next    : predicted next PC carried down the pipe
//   redirect       : registered one-cycle pulse on mispredict
//   redirect_pc    : registered correct next PC of the last resolve
//   mispredict_cnt : saturating mispredict count

module branch_predict_unit #(
    parameter int WIDTH     = 32,
    parameter int BTB_DEPTH = 16,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] f_pc,
    output logic             f_pred_taken,
    output logic [WIDTH-1:0] f_pred_next,
    input  logic             r_valid,
    input  logic [WIDTH-1:0] r_pc,
    input  logic [WIDTH-1:0] r_offset,
    input  logic             r_taken,
    input  logic             r_pred_taken,
    input  logic [WIDTH-1:0] r_pred_next,
    output logic             redirect,
    output logic [WIDTH-1:0] redirect_pc,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = WIDTH - IDX_W;

    // BTB storage; only valid and ctr need reset, tag/target are don't-care while invalid
    logic             btbValid_q  [BTB_DEPTH];
    logic [1:0]       btbCtr_q    [BTB_DEPTH];
    logic [TAG_W-1:0] btbTag_q    [BTB_DEPTH];
    logic [WIDTH-1:0] btbTarget_q [BTB_DEPTH];

    logic             redirect_q,     redirect_d;
    logic [WIDTH-1:0] redirectPc_q,   redirectPc_d;
    logic [CNT_W-1:0] mispredictCnt_q, mispredictCnt_d;

    // The full next-PC compare already covers direction and target errors,
    // so the carried taken bit is not needed to detect a mispredict
    logic unusedPredTaken;
    assign unusedPredTaken = r_pred_taken;

    // Fetch-side lookup sees the pre-update table contents
    logic [IDX_W-1:0] fIdx;
    logic [TAG_W-1:0] fTag;
    logic             fHit;

    assign fIdx         = f_pc[IDX_W-1:0];
    assign fTag         = f_pc[WIDTH-1:IDX_W];
    assign fHit         = btbValid_q[fIdx] && (btbTag_q[fIdx] == fTag);
    assign f_pred_taken = fHit && btbCtr_q[fIdx][1];
    assign f_pred_next  = f_pred_taken ? btbTarget_q[fIdx] : f_pc + WIDTH'(1);

    // Resolve-side: actual next PC, mispredict detection and BTB write data
    logic [IDX_W-1:0] rIdx;
    logic [TAG_W-1:0] rTag;
    logic             rHit;
    logic [WIDTH-1:0] rSeq;
    logic [WIDTH-1:0] rTgt;
    logic [WIDTH-1:0] rActual;
    logic             rMispredict;
    logic             wrEn;
    logic [1:0]       wrCtr;
    logic [WIDTH-1:0] wrTarget;

    assign rIdx = r_pc[IDX_W-1:0];
    assign rTag = r_pc[WIDTH-1:IDX_W];
    assign rHit = btbValid_q[rIdx] && (btbTag_q[rIdx] == rTag);

    always_comb begin
        rSeq            = r_pc + WIDTH'(1);
        rTgt            = rSeq + r_offset;
        rActual         = r_taken ? rTgt : rSeq;
        rMispredict     = (r_pred_next != rActual);
        redirect_d      = 1'b0;
        redirectPc_d    = redirectPc_q;
        mispredictCnt_d = mispredictCnt_q;
        wrEn            = 1'b0;
        wrCtr           = btbCtr_q[rIdx];
        wrTarget        = btbTarget_q[rIdx];
        if (r_valid) begin
            redirect_d   = rMispredict;
            redirectPc_d = rActual;
            if (rMispredict && (mispredictCnt_q != {CNT_W{1'b1}}))
                mispredictCnt_d = mispredictCnt_q + CNT_W'(1);
            // Hits always train; a miss allocates only when taken
            if (rHit) begin
                wrEn = 1'b1;
                if (r_taken) begin
                    wrCtr    = (btbCtr_q[rIdx] == 2'b11) ? 2'b11 : btbCtr_q[rIdx] + 2'b01;
                    wrTarget = rTgt;
                end else begin
                    wrCtr    = (btbCtr_q[rIdx] == 2'b00) ? 2'b00 : btbCtr_q[rIdx] - 2'b01;
                end
            end else if (r_taken) begin
                wrEn     = 1'b1;
                wrCtr    = 2'b10;
                wrTarget = rTgt;
            end
        end
    end

    // Reset-cleared state: entry valid/ctr and the redirect/counter outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                btbValid_q[i] <= 1'b0;
                btbCtr_q[i]   <= 2'b00;
            end
            redirect_q      <= 1'b0;
            redirectPc_q    <= '0;
            mispredictCnt_q <= '0;
        end else begin
            if (wrEn) begin
                btbValid_q[rIdx] <= 1'b1;
                btbCtr_q[rIdx]   <= wrCtr;
            end
            redirect_q      <= redirect_d;
            redirectPc_q    <= redirectPc_d;
            mispredictCnt_q <= mispredictCnt_d;
        end
    end

    // Tag/target payload without reset; blocked while reset is held
    always_ff @(posedge clk) begin
        if (wrEn && !rst) begin
            btbTag_q[rIdx]    <= rTag;
            btbTarget_q[rIdx] <= wrTarget;
        end
    end

    assign redirect       = redirect_q;
    assign redirect_pc    = redirectPc_q;
    assign mispredict_cnt = mispredictCnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit
//   Directed test of branch_predict_unit with CNT_W=4 so counter saturation
//   is reachable quickly. Each test task drives its scenario and compares
//   outputs against hand-computed values.

module tb_branch_predict_unit;

    logic        clk;
    logic        rst;
    logic [31:0] fPc;
    logic        fPredTaken;
    logic [31:0] fPredNext;
    logic        rValid;
    logic [31:0] rPc;
    logic [31:0] rOffset;
    logic        rTaken;
    logic        rPredTaken;
    logic [31:0] rPredNext;
    logic        redirect;
    logic [31:0] redirectPc;
    logic [3:0]  mispredictCnt;

    int testCount;
    int failCount;

    branch_predict_unit #(
        .WIDTH(32),
        .BTB_DEPTH(16),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .f_pc(fPc),
        .f_pred_taken(fPredTaken),
        .f_pred_next(fPredNext),
        .r_valid(rValid),
        .r_pc(rPc),
        .r_offset(rOffset),
        .r_taken(rTaken),
        .r_pred_taken(rPredTaken),
        .r_pred_next(rPredNext),
        .redirect(redirect),
        .redirect_pc(redirectPc),
        .mispredict_cnt(mispredictCnt)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one resolve for a single cycle; returns 1 time unit after the edge
    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] off,
                                 input logic taken, input logic [31:0] predNext);
        rValid     = 1'b1;
        rPc        = pc;
        rOffset    = off;
        rTaken     = taken;
        rPredNext  = predNext;
        rPredTaken = (predNext != pc + 32'd1);
        @(posedge clk);
        #1;
        rValid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #12;
        testCount++; if (redirect !== 1'b0) begin failCount++; $display("[TB] FAIL rst_redirect: got %0h expected 0", redirect); end
        testCount++; if (redirectPc !== 32'h0) begin failCount++; $display("[TB] FAIL rst_redirect_pc: got %0h expected 0", redirectPc); end
        testCount++; if (mispredictCnt !== 4'h0) begin failCount++; $display("[TB] FAIL rst_cnt: got %0h expected 0", mispredictCnt); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        fPc = 32'h40;
        #1;
        testCount++; if (fPredTaken !== 1'b0) begin failCount++; $display("[TB] FAIL rst_pred_taken: got %0h expected 0", fPredTaken); end
        testCount++; if (fPredNext !== 32'h41) begin failCount++; $display("[TB] FAIL rst_pred_next: got %0h expected 41", fPredNext); end
    endtask

    task automatic test_cold_taken;
        applyStimulus(32'h40, 32'h10, 1'b1, 32'h41);
        testCount++; if (redirect !== 1'b1) begin failCount++; $display("[TB] FAIL cold_redirect: got %0h expected 1", redirect); end
        testCount++; if (redirectPc !== 32'h51) begin failCount++; $display("[TB] FAIL cold_redirect_pc: got %0h expected 51", redirectPc); end
        testCount++; if (mispredictCnt !== 4'd1) begin failCount++; $display("[TB] FAIL cold_cnt: got %0h expected 1", mispredictCnt); end
        fPc = 32'h40;
        #1;
        testCount++; if (fPredTaken !== 1'b1) begin failCount++; $display("[TB] FAIL cold_pred_taken: got %0h expected 1", fPredTaken); end
        testCount++; if (fPredNext !== 32'h51) begin failCount++; $display("[TB] FAIL cold_pred_next: got %0h expected 51", fPredNext); end
    endtask

    task automatic test_training;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(32'h40, 32'h10, 1'b1, 32'h51);
            testCount++; if (redirect !== 1'b0) begin failCount++; $display("[TB] FAIL train_taken_redirect%0d: got %0h expected 0", i, redirect); end
            testCount++; if (redirectPc !== 32'h51) begin failCount++; $display("[TB] FAIL train_taken_pc%0d: got %0h expected 51", i, redirectPc); end
        end
        testCount++; if (mispredictCnt !== 4'd1) begin failCount++; $display("[TB] FAIL train_taken_cnt: got %0h expected 1", mispredictCnt); end
        applyStimulus(32'h40, 32'h10, 1'b0, 32'h51);
        testCount++; if (redirect !== 1'b1) begin failCount++; $display("[TB] FAIL train_nt1_redirect: got %0h expected 1", redirect); end
        testCount++; if (redirectPc !== 32'h41) begin failCount++; $display("[TB] FAIL train_nt1_pc: got %0h expected 41", redirectPc); end
        testCount++; if (mispredictCnt !== 4'd2) begin failCount++; $display("[TB] FAIL train_nt1_cnt: got %0h expected 2", mispredictCnt); end
        #1;
        testCount++; if (fPredTaken !== 1'b1) begin failCount++; $display("[TB] FAIL train_ctr10_taken: got %0h expected 1", fPredTaken); end
        applyStimulus(32'h40, 32'h10, 1'b0, 32'h51);
        testCount++; if (mispredictCnt !== 4'd3) begin failCount++; $display("[TB] FAIL train_nt2_cnt: got %0h expected 3", mispredictCnt); end
        #1;
        testCount++; if (fPredTaken !== 1'b0) begin failCount++; $display("[TB] FAIL train_ctr01_taken: got %0h expected 0", fPredTaken); end
        testCount++; if (fPredNext !== 32'h41) begin failCount++; $display("[TB] FAIL train_ctr01_next: got %0h expected 41", fPredNext); end
        @(posedge clk);
        #1;
        testCount++; if (redirect !== 1'b0) begin failCount++; $display("[TB] FAIL idle_redirect: got %0h expected 0", redirect); end
        testCount++; if (redirectPc !== 32'h41) begin failCount++; $display("[TB] FAIL idle_pc_hold: got %0h expected 41", redirectPc); end
        testCount++; if (mispredictCnt !== 4'd3) begin failCount++; $display("[TB] FAIL idle_cnt_hold: got %0h expected 3", mispredictCnt); end
    endtask

    task automatic test_alias;
        applyStimulus(32'h40, 32'h10, 1'b1, 32'h41);
        fPc = 32'h40;
        #1;
        testCount++; if (fPredNext !== 32'h51) begin failCount++; $display("[TB] FAIL alias_retrain_next: got %0h expected 51", fPredNext); end
        applyStimulus(32'h140, 32'h10, 1'b1, 32'h141);
        testCount++; if (mispredictCnt !== 4'd5) begin failCount++; $display("[TB] FAIL alias_cnt: got %0h expected 5", mispredictCnt); end
        fPc = 32'h40;
        #1;
        testCount++; if (fPredTaken !== 1'b0) begin failCount++; $display("[TB] FAIL alias_old_taken: got %0h expected 0", fPredTaken); end
        testCount++; if (fPredNext !== 32'h41) begin failCount++; $display("[TB] FAIL alias_old_next: got %0h expected 41", fPredNext); end
        fPc = 32'h140;
        #1;
        testCount++; if (fPredTaken !== 1'b1) begin failCount++; $display("[TB] FAIL alias_new_taken: got %0h expected 1", fPredTaken); end
        testCount++; if (fPredNext !== 32'h151) begin failCount++; $display("[TB] FAIL alias_new_next: got %0h expected 151", fPredNext); end
    endtask

    task automatic test_wrap;
        applyStimulus(32'h10, 32'hFFFF_FFF0, 1'b1, 32'h11);
        testCount++; if (redirect !== 1'b1) begin failCount++; $display("[TB] FAIL back_redirect: got %0h expected 1", redirect); end
        testCount++; if (redirectPc !== 32'h1) begin failCount++; $display("[TB] FAIL back_pc: got %0h expected 1", redirectPc); end
        testCount++; if (mispredictCnt !== 4'd6) begin failCount++; $display("[TB] FAIL back_cnt: got %0h expected 6", mispredictCnt); end
        applyStimulus(32'hFFFF_FFFF, 32'h5, 1'b0, 32'h0);
        testCount++; if (redirect !== 1'b0) begin failCount++; $display("[TB] FAIL wrap_redirect: got %0h expected 0", redirect); end
        testCount++; if (redirectPc !== 32'h0) begin failCount++; $display("[TB] FAIL wrap_pc: got %0h expected 0", redirectPc); end
        testCount++; if (mispredictCnt !== 4'd6) begin failCount++; $display("[TB] FAIL wrap_cnt: got %0h expected 6", mispredictCnt); end
        fPc = 32'hFFFF_FFFF;
        #1;
        testCount++; if (fPredNext !== 32'h0) begin failCount++; $display("[TB] FAIL wrap_fetch_next: got %0h expected 0", fPredNext); end
    endtask

    task automatic test_same_cycle;
        fPc        = 32'h23;
        rValid     = 1'b1;
        rPc        = 32'h23;
        rOffset    = 32'h5;
        rTaken     = 1'b1;
        rPredNext  = 32'h24;
        rPredTaken = 1'b0;
        #1;
        testCount++; if (fPredTaken !== 1'b0) begin failCount++; $display("[TB] FAIL same_pre_taken: got %0h expected 0", fPredTaken); end
        testCount++; if (fPredNext !== 32'h24) begin failCount++; $display("[TB] FAIL same_pre_next: got %0h expected 24", fPredNext); end
        @(posedge clk);
        #1;
        rValid = 1'b0;
        testCount++; if (fPredTaken !== 1'b1) begin failCount++; $display("[TB] FAIL same_post_taken: got %0h expected 1", fPredTaken); end
        testCount++; if (fPredNext !== 32'h29) begin failCount++; $display("[TB] FAIL same_post_next: got %0h expected 29", fPredNext); end
        testCount++; if (mispredictCnt !== 4'd7) begin failCount++; $display("[TB] FAIL same_cnt: got %0h expected 7", mispredictCnt); end
    endtask

    task automatic test_async_reset;
        applyStimulus(32'h80, 32'h0, 1'b0, 32'h0);
        testCount++; if (redirect !== 1'b1) begin failCount++; $display("[TB] FAIL prerst_redirect: got %0h expected 1", redirect); end
        rValid     = 1'b1;
        rPc        = 32'h33;
        rOffset    = 32'h7;
        rTaken     = 1'b1;
        rPredNext  = 32'h0;
        rPredTaken = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        testCount++; if (redirect !== 1'b0) begin failCount++; $display("[TB] FAIL arst_redirect: got %0h expected 0", redirect); end
        testCount++; if (redirectPc !== 32'h0) begin failCount++; $display("[TB] FAIL arst_pc: got %0h expected 0", redirectPc); end
        testCount++; if (mispredictCnt !== 4'h0) begin failCount++; $display("[TB] FAIL arst_cnt: got %0h expected 0", mispredictCnt); end
        @(posedge clk);
        #1;
        rst    = 1'b0;
        rValid = 1'b0;
        fPc    = 32'h33;
        #1;
        testCount++; if (fPredTaken !== 1'b0) begin failCount++; $display("[TB] FAIL arst_no_alloc: got %0h expected 0", fPredTaken); end
        testCount++; if (redirectPc !== 32'h0) begin failCount++; $display("[TB] FAIL arst_pc_after: got %0h expected 0", redirectPc); end
        fPc = 32'h140;
        #1;
        testCount++; if (fPredNext !== 32'h141) begin failCount++; $display("[TB] FAIL arst_btb_cleared: got %0h expected 141", fPredNext); end
    endtask

    task automatic test_back_to_back_saturate;
        for (int i = 0; i < 15; i++) applyStimulus(32'h80, 32'h0, 1'b0, 32'h0);
        testCount++; if (mispredictCnt !== 4'hF) begin failCount++; $display("[TB] FAIL sat_reach: got %0h expected f", mispredictCnt); end
        testCount++; if (redirect !== 1'b1) begin failCount++; $display("[TB] FAIL sat_redirect: got %0h expected 1", redirect); end
        applyStimulus(32'h80, 32'h0, 1'b0, 32'h0);
        testCount++; if (mispredictCnt !== 4'hF) begin failCount++; $display("[TB] FAIL sat_hold: got %0h expected f", mispredictCnt); end
        testCount++; if (redirectPc !== 32'h81) begin failCount++; $display("[TB] FAIL sat_pc: got %0h expected 81", redirectPc); end
    endtask

    // Sequence of directed scenarios; BTB state carries from one task to the next
    initial begin
        testCount  = 0;
        failCount  = 0;
        rValid     = 1'b0;
        rPc        = '0;
        rOffset    = '0;
        rTaken     = 1'b0;
        rPredTaken = 1'b0;
        rPredNext  = '0;
        fPc        = '0;
        test_reset();
        test_cold_taken();
        test_training();
        test_alias();
        test_wrap();
        test_same_cycle();
        test_async_reset();
        test_back_to_back_saturate();
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
